// File: rtl/time_of_day_counter.sv
// time_of_day_counter
// Divides the i_tick pulse down to seconds and keeps binary hh:mm:ss wall-clock
// time with a midnight wrap. Time is set through a valid/ready load port; bad
// fields are rejected with a one-cycle o_load_err pulse. o_sec_pulse and
// o_day_pulse are registered strobes aligned with the time update.
// Optional feature macro: TIME_OF_DAY_ALARM_EN adds a sticky hh:mm alarm.
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SUB_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_load_valid,
  output logic       o_load_ready,
  input  logic [4:0] i_load_hh,
  input  logic [5:0] i_load_mm,
  input  logic [5:0] i_load_ss,
  output logic       o_load_err,
  output logic [4:0] o_hh,
  output logic [5:0] o_mm,
  output logic [5:0] o_ss,
  output logic       o_sec_pulse,
  output logic       o_day_pulse
`ifdef TIME_OF_DAY_ALARM_EN
  ,
  input  logic       i_alarm_arm,
  input  logic [4:0] i_alarm_hh,
  input  logic [5:0] i_alarm_mm,
  output logic       o_alarm
`endif
);

  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_ONE = SUB_W'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [SUB_W-1:0] sub_r;
  logic [4:0]       hh_r, hh_adv_s;
  logic [5:0]       mm_r, mm_adv_s;
  logic [5:0]       ss_r, ss_adv_s;
  logic             ready_r, err_r, sec_pulse_r, day_pulse_r;
  logic             accept_s, fields_ok_s, load_s, load_err_s;
  logic             count_s, sec_adv_s, day_wrap_s;

  // A load is only taken while ready; out-of-range fields turn it into an error.
  assign accept_s    = i_load_valid & ready_r;
  assign fields_ok_s = (i_load_hh <= 5'd23) & (i_load_mm <= 6'd59) & (i_load_ss <= 6'd59);
  assign load_s      = accept_s & fields_ok_s;
  assign load_err_s  = accept_s & ~fields_ok_s;
  // A valid load on the same edge as a tick discards the tick.
  assign count_s     = (state_r == ST_RUN) & i_tick & ~load_s;
  assign sec_adv_s   = count_s & (sub_r == SUB_MAX);

  // Next-state logic for the STOP/RUN/LOAD controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_STOP: begin
        if (load_s)     state_s = ST_LOAD;
        else if (i_run) state_s = ST_RUN;
        else            state_s = ST_STOP;
      end
      ST_RUN: begin
        if (load_s)      state_s = ST_LOAD;
        else if (!i_run) state_s = ST_STOP;
        else             state_s = ST_RUN;
      end
      ST_LOAD: begin
        if (i_run) state_s = ST_RUN;
        else       state_s = ST_STOP;
      end
      default: state_s = ST_STOP;
    endcase
  end

  // Time value one second ahead of the current registers, with carries.
  always_comb begin
    ss_adv_s   = ss_r;
    mm_adv_s   = mm_r;
    hh_adv_s   = hh_r;
    day_wrap_s = 1'b0;
    if (ss_r >= 6'd59) begin
      ss_adv_s = 6'd0;
      if (mm_r >= 6'd59) begin
        mm_adv_s = 6'd0;
        if (hh_r >= 5'd23) begin
          hh_adv_s   = 5'd0;
          day_wrap_s = 1'b1;
        end else begin
          hh_adv_s = hh_r + 5'd1;
        end
      end else begin
        mm_adv_s = mm_r + 6'd1;
      end
    end else begin
      ss_adv_s = ss_r + 6'd1;
    end
  end

  // Controller state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= ST_STOP;
    else         state_r <= state_s;
  end

  // Sub-second counter: cleared by a load, held while not running.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       sub_r <= '0;
    else if (load_s)   sub_r <= '0;
    else if (count_s)  sub_r <= sec_adv_s ? '0 : (sub_r + SUB_ONE);
    else               sub_r <= sub_r;
  end

  // Time-of-day registers: a load takes priority over a seconds advance.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hh_r <= 5'd0;
      mm_r <= 6'd0;
      ss_r <= 6'd0;
    end else if (load_s) begin
      hh_r <= i_load_hh;
      mm_r <= i_load_mm;
      ss_r <= i_load_ss;
    end else if (sec_adv_s) begin
      hh_r <= hh_adv_s;
      mm_r <= mm_adv_s;
      ss_r <= ss_adv_s;
    end
  end

  // Registered handshake and strobe outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      sec_pulse_r <= 1'b0;
      day_pulse_r <= 1'b0;
    end else begin
      ready_r     <= (state_s != ST_LOAD);
      err_r       <= load_err_s;
      sec_pulse_r <= sec_adv_s;
      day_pulse_r <= sec_adv_s & day_wrap_s;
    end
  end

`ifdef TIME_OF_DAY_ALARM_EN
  logic alarm_r, alarm_hit_s;

  // Only a seconds advance onto hh:mm:00 can fire the alarm, never a load.
  assign alarm_hit_s = sec_adv_s & i_alarm_arm & (hh_adv_s == i_alarm_hh) &
                       (mm_adv_s == i_alarm_mm) & (ss_adv_s == 6'd0);

  // Sticky alarm flag, cleared by disarming.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)          alarm_r <= 1'b0;
    else if (alarm_hit_s) alarm_r <= 1'b1;
    else if (!i_alarm_arm) alarm_r <= 1'b0;
  end

  assign o_alarm = alarm_r;
`endif

  assign o_load_ready = ready_r;
  assign o_load_err   = err_r;
  assign o_hh         = hh_r;
  assign o_mm         = mm_r;
  assign o_ss         = ss_r;
  assign o_sec_pulse  = sec_pulse_r;
  assign o_day_pulse  = day_pulse_r;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Testbench for time_of_day_counter: directed scenarios plus randomized traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;
  localparam int TPS = 4;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_tick, i_run, i_load_valid;
  logic [4:0] i_load_hh;
  logic [5:0] i_load_mm, i_load_ss;
  logic       o_load_ready, o_load_err, o_sec_pulse, o_day_pulse;
  logic [4:0] o_hh;
  logic [5:0] o_mm, o_ss;
`ifdef TIME_OF_DAY_ALARM_EN
  logic       i_alarm_arm = 1'b0;
  logic [4:0] i_alarm_hh = 5'd0;
  logic [5:0] i_alarm_mm = 6'd0;
  logic       o_alarm;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time as seconds since midnight.
  int m_t, m_sub;
  bit m_running, m_ready, m_sec, m_day, m_err, m_alarm;

  time_of_day_counter #(.TICKS_PER_SEC(TPS), .SUB_W(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_tick(i_tick), .i_run(i_run),
    .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
    .i_load_hh(i_load_hh), .i_load_mm(i_load_mm), .i_load_ss(i_load_ss),
    .o_load_err(o_load_err), .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss),
    .o_sec_pulse(o_sec_pulse), .o_day_pulse(o_day_pulse)
`ifdef TIME_OF_DAY_ALARM_EN
    ,
    .i_alarm_arm(i_alarm_arm), .i_alarm_hh(i_alarm_hh), .i_alarm_mm(i_alarm_mm),
    .o_alarm(o_alarm)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("hh", o_hh, m_t / 3600);
    chk("mm", o_mm, (m_t / 60) % 60);
    chk("ss", o_ss, m_t % 60);
    chk("ready", o_load_ready, m_ready);
    chk("err", o_load_err, m_err);
    chk("sec_pulse", o_sec_pulse, m_sec);
    chk("day_pulse", o_day_pulse, m_day);
`ifdef TIME_OF_DAY_ALARM_EN
    chk("alarm", o_alarm, m_alarm);
`endif
  endtask

  task automatic model_update(input bit tick, input bit run, input bit lv,
                              input int hh, input int mm, input int ss);
    bit acc, ok;
    acc = lv && m_ready;
    ok  = (hh < 24) && (mm < 60) && (ss < 60);
    m_sec = 0; m_day = 0; m_err = 0;
    if (acc && ok) begin
      m_t = hh * 3600 + mm * 60 + ss;
      m_sub = 0;
    end else begin
      m_err = acc;
      if (m_running && tick) begin
        m_sub++;
        if (m_sub == TPS) begin
          m_sub = 0;
          m_t = (m_t + 1) % 86400;
          m_sec = 1;
          m_day = (m_t == 0);
        end
      end
    end
`ifdef TIME_OF_DAY_ALARM_EN
    if (m_sec && i_alarm_arm && m_t == int'(i_alarm_hh) * 3600 + int'(i_alarm_mm) * 60)
      m_alarm = 1;
    else if (!i_alarm_arm)
      m_alarm = 0;
`endif
    m_running = run && !(acc && ok);
    m_ready   = !(acc && ok);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit tick, input bit run, input bit lv,
                      input int hh, input int mm, input int ss);
    i_tick = tick; i_run = run; i_load_valid = lv;
    i_load_hh = hh[4:0]; i_load_mm = mm[5:0]; i_load_ss = ss[5:0];
    @(posedge i_clk);
    model_update(tick, run, lv, hh, mm, ss);
    #1;
    check_all();
  endtask

  task automatic idle(input bit run);
    step(1'b0, run, 1'b0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input bit run);
    for (int k = 0; k < n; k++) step(1'b1, run, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_tick = 1'b0; i_run = 1'b0; i_load_valid = 1'b0;
    i_load_hh = 5'd0; i_load_mm = 6'd0; i_load_ss = 6'd0;
    #1;
    m_t = 0; m_sub = 0; m_running = 0; m_ready = 0;
    m_sec = 0; m_day = 0; m_err = 0; m_alarm = 0;
    check_all();
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    int hh, mm, ss, sel;
    bit tick, run, lv, bad;

    // Reset and first second.
    do_reset();
    chk("rst_ready", o_load_ready, 0);
    idle(1'b1);
    chk("ready_after_rst", o_load_ready, 1);
    ticks(3, 1'b1);
    chk("t1_ss_before", o_ss, 0);
    ticks(1, 1'b1);
    chk("t1_ss", o_ss, 1);
    chk("t1_sec_pulse", o_sec_pulse, 1);
    chk("t1_model_ss", m_t % 60, 1);
    idle(1'b1);
    chk("t1_sec_pulse_off", o_sec_pulse, 0);

    // Midnight wrap.
    step(1'b0, 1'b1, 1'b1, 23, 59, 59);
    chk("ld_hh", o_hh, 23);
    chk("ld_ready_low", o_load_ready, 0);
    idle(1'b1);
    chk("ld_ready_back", o_load_ready, 1);
    ticks(4, 1'b1);
    chk("wrap_hh", o_hh, 0);
    chk("wrap_mm", o_mm, 0);
    chk("wrap_ss", o_ss, 0);
    chk("wrap_sec", o_sec_pulse, 1);
    chk("wrap_day", o_day_pulse, 1);
    chk("wrap_model_day", m_day, 1);

    // Rejected loads.
    step(1'b0, 1'b1, 1'b1, 24, 0, 0);
    chk("bad_hh_err", o_load_err, 1);
    chk("bad_hh_time", o_hh, 0);
    idle(1'b1);
    chk("bad_hh_err_off", o_load_err, 0);
    step(1'b0, 1'b1, 1'b1, 0, 60, 0);
    chk("bad_mm_err", o_load_err, 1);
    chk("bad_mm_time", o_mm, 0);
    idle(1'b1);
    chk("bad_mm_err_off", o_load_err, 0);

    // Tick coincident with a valid load: load wins, sub-counter cleared.
    ticks(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 12, 34, 56);
    chk("tl_hh", o_hh, 12);
    chk("tl_mm", o_mm, 34);
    chk("tl_ss", o_ss, 56);
    chk("tl_ready", o_load_ready, 0);
    idle(1'b1);
    chk("tl_ready_back", o_load_ready, 1);
    ticks(3, 1'b1);
    chk("tl_ss_hold", o_ss, 56);
    ticks(1, 1'b1);
    chk("tl_ss_adv", o_ss, 57);

    // Pausing mid-second keeps the sub-counter.
    ticks(2, 1'b1);
    idle(1'b0);
    ticks(10, 1'b0);
    chk("pause_ss", o_ss, 57);
    idle(1'b1);
    ticks(1, 1'b1);
    chk("resume_ss_hold", o_ss, 57);
    ticks(1, 1'b1);
    chk("resume_ss_adv", o_ss, 58);

`ifdef TIME_OF_DAY_ALARM_EN
    // Alarm: fires on advance, sticky, cleared by disarm, not set by a load.
    i_alarm_hh = 5'd7; i_alarm_mm = 6'd30; i_alarm_arm = 1'b1;
    step(1'b0, 1'b1, 1'b1, 7, 29, 59);
    idle(1'b1);
    ticks(4, 1'b1);
    chk("alarm_set", o_alarm, 1);
    ticks(6, 1'b1);
    chk("alarm_sticky", o_alarm, 1);
    i_alarm_arm = 1'b0;
    idle(1'b1);
    chk("alarm_clear", o_alarm, 0);
    i_alarm_arm = 1'b1;
    step(1'b0, 1'b1, 1'b1, 7, 30, 0);
    idle(1'b1);
    chk("alarm_load_no", o_alarm, 0);
    step(1'b0, 1'b1, 1'b1, 7, 29, 59);
    idle(1'b1);
    ticks(4, 1'b1);
    chk("alarm_set2", o_alarm, 1);
    do_reset();
    chk("alarm_rst", o_alarm, 0);
    i_alarm_hh = 5'd0; i_alarm_mm = 6'd0; i_alarm_arm = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      tick = 1'($urandom_range(0, 1));
      run  = ($urandom_range(0, 9) != 0);
      lv   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) begin
        hh = 23; mm = 59; ss = int'($urandom_range(50, 59));
      end else begin
        hh = int'($urandom_range(0, 23)); mm = int'($urandom_range(0, 59));
        ss = int'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 2));
        if (sel == 0)      hh = int'($urandom_range(24, 31));
        else if (sel == 1) mm = int'($urandom_range(60, 63));
        else               ss = int'($urandom_range(60, 63));
      end
      bad = !((hh < 24) && (mm < 60) && (ss < 60));
      if (lv && bad) tick = 1'b0;
`ifdef TIME_OF_DAY_ALARM_EN
      if ($urandom_range(0, 99) == 0) i_alarm_arm = ~i_alarm_arm;
`endif
      step(tick, run, lv, hh, mm, ss);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
